// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: opcodes, reset defaults,
// IF/ID field widths and the self-jump detector.
package if_fetch_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned JTARGET_W = 26;

  localparam logic [OPCODE_W-1:0] OP_J   = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE = 6'b000101;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT  = 32'h0040_0000;

  // A J whose pseudo-direct target equals its own address spins forever.
  function automatic logic is_self_jump(input logic [INSTR_W-1:0] instr,
                                        input logic [XLEN-1:0]    pc_plus4);
    logic [XLEN-1:0] target;
    target = {pc_plus4[31:28], instr[JTARGET_W-1:0], 2'b00};
    return (instr[31:26] == OP_J) && (target == pc_plus4 - 32'd4);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble insertion takes priority over hold.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bubble,
  input  logic               hold,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [XLEN-1:0]    next_pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    pc_plus4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_q;
  logic [XLEN-1:0]    pc_plus4_q;
  logic               valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!hold) begin
      instr_q    <= next_instr;
      pc_plus4_q <= next_pc_plus4;
      valid_q    <= 1'b1;
    end
  end

  assign instr    = instr_q;
  assign pc_plus4 = pc_plus4_q;
  assign valid    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, IF/ID capture,
// sticky self-jump halt flag and a count of valid fetches.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int unsigned        CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [XLEN-1:0]    if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  logic [XLEN-1:0]  pc_q, pc_d, pc_plus4;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             squash, load;

  assign pc_plus4 = pc_q + 32'd4;
  // The wrong-path word fetched alongside a redirect is never allowed into IF/ID.
  assign squash   = flush | redirect_valid;
  assign load     = !squash && !stall;

  always_comb begin
    pc_d = pc_plus4;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'd3;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    cnt_d    = load ? cnt_q + CNT_W'(1) : cnt_q;
    halted_d = halted_q | (if_id_valid && is_self_jump(if_id_instr, if_id_pc_plus4));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  if_fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .bubble        (squash),
    .hold          (stall),
    .next_instr    (imem_data),
    .next_pc_plus4 (pc_plus4),
    .instr         (if_id_instr),
    .pc_plus4      (if_id_pc_plus4),
    .valid         (if_id_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the word address into the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register.
- Honours stall, flush and redirect (branch/jump) requests from later stages.
- Adds a sticky self-jump halt detector and a fetched-instruction counter for bench and debug use.

Parameters:
RESET_PC, 32'h00400000, PC value after reset (text-segment base)
NOP_INSTR, 32'h00000000, word placed in IF/ID on flush/bubble
CNT_W, 32, width of fetch_count

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC and IF/ID contents (load-use hazard)
flush  in  1  replace IF/ID contents with bubble next edge
redirect_valid  in  1  load redirect_pc into PC next edge
redirect_pc  in  32  branch/jump target from ID/EX
imem_addr  out  32  byte address to instruction memory (= PC)
imem_data  in  32  instruction word, combinational from memory
if_id_instr  out  32  latched instruction
if_id_pc_plus4  out  32  latched PC+4 of that instruction
if_id_valid  out  1  1 = real instruction, 0 = bubble
halted  out  1  sticky: self-jump reached IF/ID
fetch_count  out  CNT_W  valid instructions latched into IF/ID

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0, halted=0, fetch_count=0.
  - On release, the first edge latches the word at RESET_PC.
- imem_addr = PC, combinational. Memory data is consumed in the same cycle, so latency from PC to IF/ID is one edge.
- PC update per edge, in priority order:
  - redirect_valid: PC = {redirect_pc[31:2],2'b00}. Overrides stall.
  - stall: PC holds.
  - otherwise: PC = PC+4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000, no flag).
- IF/ID update per edge, in priority order:
  - flush or redirect_valid: instr=NOP_INSTR, pc_plus4=0, valid=0. The wrong-path fetch is squashed; flush overrides stall.
  - stall: all IF/ID fields hold.
  - otherwise: instr=imem_data, pc_plus4=PC+4, valid=1.
- fetch_count:
  - Increments by 1 on each edge that loads valid=1.
  - Wraps at 2^CNT_W.
  - Does not increment on stall or squash.
- halted:
  - Sets at the edge after IF/ID holds valid=1 and opcode if_id_instr[31:26]=6'b000010 (J).
  - Condition: {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00} == if_id_pc_plus4-4.
  - Once set, clears only on reset. Fetching continues unaffected.
- Simultaneous stall+flush+redirect_valid: PC takes redirect, IF/ID becomes bubble.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of stall/redirect.
- Purely synchronous except reset. No combinational path from stall/flush/redirect to imem_addr.

Decomposition:
- Shared pipeline package holds:
  - opcode constants (OP_J=6'b000010, OP_JAL, OP_BEQ, OP_BNE)
  - NOP_INSTR
  - RESET_PC default
  - IF/ID bundle field widths
- One natural sub-module: if_id_reg (IF/ID register with hold/bubble controls).
- PC register and next-PC logic stay in if_fetch_stage.

Test Plan:
- Reset release, no stall, memory words 0x20080001, 0x00084820, 0x01285020: cycles 1..3 show if_id_instr in that order, with if_id_pc_plus4 = 0x00400004/08/0C, valid=1, fetch_count=3.
- stall held 2 cycles while PC=0x00400008: imem_addr stays 0x00400008, IF/ID unchanged, fetch_count unchanged; after release, PC advances to 0x0040000C.
- redirect_valid=1, redirect_pc=0x00400003, with stall=1: next PC=0x00400000, if_id_valid=0, if_id_instr=0x00000000; the following edge latches the word at 0x00400000.
- flush=1 alone at PC=0x00400010: IF/ID becomes bubble, PC advances to 0x00400014, fetch_count not incremented.
- Word 0x08100005 at 0x00400014 reaches IF/ID valid: halted=1 on the next edge and stays 1 through further fetches and redirects.
- Reset pulsed low mid-stream with PC=0x00400010 and halted=1: outputs return to reset values immediately without a clock edge, and PC restarts at 0x00400000 on release.
